// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared single-port memory arbiter for fetch and data ports
module mem_port_arbiter #(
  parameter int AW         = 9,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [1:0]    d_size,
  input  logic          d_se,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          mem_e,
  output logic          mem_rw,
  output logic [1:0]    mem_size,
  output logic          mem_se,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_di,
  input  logic [31:0]   mem_do,
  output logic          stall_F,
  output logic          stall_M,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   streak;
  logic            sel_d;
  logic [AW-1:0]   r_addr;
  logic            r_rw;
  logic [1:0]      r_size;
  logic            r_se;
  logic [31:0]     r_wdata;
  logic            grant_d;
  logic            grant_i;

  // Data wins unless fetch has waited through STARVE_MAX data grants in a row
  assign grant_d = d_req && !(if_req && (streak == SW'(STARVE_MAX)));
  assign grant_i = !grant_d && if_req;

  assign stall_F = if_req & ~if_ack;
  assign stall_M = d_req & ~d_ack;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one grant per pass, RESP always falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: memory bus driven only from latched request while in ACCESS
  always_comb begin
    mem_e    = 1'b0;
    mem_rw   = 1'b0;
    mem_size = 2'b00;
    mem_se   = 1'b0;
    mem_addr = '0;
    mem_di   = 32'd0;
    if (state == ACCESS) begin
      mem_e    = 1'b1;
      mem_rw   = r_rw;
      mem_size = r_size;
      mem_se   = r_se;
      mem_addr = r_addr;
      mem_di   = r_wdata;
    end
    if_ack = (state == RESP) && !sel_d;
    d_ack  = (state == RESP) && sel_d;
    busy   = (state != IDLE);
  end

  // Request latch, access countdown, starvation streak and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      streak   <= '0;
      sel_d    <= 1'b0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_size   <= 2'b00;
      r_se     <= 1'b0;
      r_wdata  <= 32'd0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            sel_d   <= 1'b1;
            r_addr  <= d_addr;
            r_rw    <= d_rw;
            r_size  <= d_size;
            r_se    <= d_se;
            r_wdata <= d_wdata;
            cnt     <= CW'(MEM_LAT - 1);
            if (!if_req)                          streak <= '0;
            else if (streak != SW'(STARVE_MAX))   streak <= streak + 1'b1;
          end else if (grant_i) begin
            sel_d   <= 1'b0;
            r_addr  <= if_addr;
            r_rw    <= 1'b0;
            r_size  <= 2'b10;
            r_se    <= 1'b0;
            r_wdata <= 32'd0;
            cnt     <= CW'(MEM_LAT - 1);
            streak  <= '0;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (sel_d) d_rdata  <= r_rw ? 32'd0 : mem_do;
            else       if_rdata <= mem_do;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_size;
  logic        d_se;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_e;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [8:0]  mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic        stall_F;
  logic        stall_M;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:511];

  always #5 clk = ~clk;

  // Simple word memory: combinational read, write on enabled store cycles
  assign mem_do = mem[mem_addr];
  always @(posedge clk) if (mem_e && mem_rw) mem[mem_addr] <= mem_di;

  mem_port_arbiter #(.AW(9), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_se(d_se), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_e(mem_e), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
    .stall_F(stall_F), .stall_M(stall_M), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Wait (bounded) for any ack, then check it came from the expected port
  task automatic wait_ack(input logic want_d, input string tag);
    int n;
    n = 0;
    while (!(if_ack || d_ack) && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, {31'd0, if_ack | d_ack}, 32'd1);
    check({tag, "_port"}, {31'd0, d_ack}, {31'd0, want_d});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[9'h010] = 32'hDEADBEEF;
    mem[9'h004] = 32'h01234567;
    mem[9'h100] = 32'hCAFEF00D;

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_size = 2'b00; d_se = 1'b0; d_addr = '0; d_wdata = '0;

    // 1: reset state
    tick(); tick();
    check("rst_mem_e",    {31'd0, mem_e}, 32'd0);
    check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_stalls",   {30'd0, stall_F, stall_M}, 32'd0);
    check("rst_acks",     {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_rdata",    if_rdata | d_rdata, 32'd0);
    reset = 1'b0;

    // 2: single fetch
    tick();
    if_req = 1'b1; if_addr = 9'h010;
    settle();
    check("f_c0_stallF", {31'd0, stall_F}, 32'd1);
    check("f_c0_mem_e",  {31'd0, mem_e}, 32'd0);
    tick();
    check("f_c1_bus", {19'd0, mem_e, mem_rw, mem_size, mem_addr}, {19'd0, 1'b1, 1'b0, 2'b10, 9'h010});
    check("f_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("f_c2_bus", {19'd0, mem_e, mem_rw, mem_size, mem_addr}, {19'd0, 1'b1, 1'b0, 2'b10, 9'h010});
    check("f_c2_stallF", {31'd0, stall_F}, 32'd1);
    tick();
    check("f_c3_ack",    {31'd0, if_ack}, 32'd1);
    check("f_c3_rdata",  if_rdata, 32'hDEADBEEF);
    check("f_c3_stallF", {31'd0, stall_F}, 32'd0);
    check("f_c3_mem_e",  {31'd0, mem_e}, 32'd0);
    if_req = 1'b0;

    // 3: simultaneous fetch and load, data first
    tick();
    check("f_c4_ack_gone", {31'd0, if_ack}, 32'd0);
    if_req = 1'b1; if_addr = 9'h004;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 9'h100;
    settle();
    check("s_c0_stallF", {31'd0, stall_F}, 32'd1);
    tick();
    check("s_c1_addr", {23'd0, mem_addr}, 32'h100);
    tick();
    tick();
    check("s_c3_dack",  {30'd0, if_ack, d_ack}, 32'd1);
    check("s_c3_drd",   d_rdata, 32'hCAFEF00D);
    check("s_c3_stallF", {31'd0, stall_F}, 32'd1);
    d_req = 1'b0;
    tick();
    check("s_c4_stallF", {31'd0, stall_F}, 32'd1);
    tick();
    check("s_c5_addr", {23'd0, mem_addr}, 32'h004);
    tick();
    check("s_c6_stallF", {31'd0, stall_F}, 32'd1);
    check("s_c6_noack",  {30'd0, if_ack, d_ack}, 32'd0);
    tick();
    check("s_c7_iack",  {30'd0, if_ack, d_ack}, 32'd2);
    check("s_c7_ird",   if_rdata, 32'h01234567);
    if_req = 1'b0;

    // 4: store then load back
    tick();
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 9'h020; d_wdata = 32'h12345678;
    settle();
    check("st_c0_stallM", {31'd0, stall_M}, 32'd1);
    tick();
    check("st_c1_rw", {30'd0, mem_e, mem_rw}, 32'd3);
    check("st_c1_di", mem_di, 32'h12345678);
    tick();
    check("st_c2_rw", {30'd0, mem_e, mem_rw}, 32'd3);
    check("st_c2_di", mem_di, 32'h12345678);
    check("st_c2_addr", {23'd0, mem_addr}, 32'h020);
    tick();
    check("st_c3_ack",   {31'd0, d_ack}, 32'd1);
    check("st_c3_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_rw = 1'b0; d_wdata = 32'd0;
    tick(); tick(); tick();
    check("ld_c3_ack",   {31'd0, d_ack}, 32'd1);
    check("ld_c3_rdata", d_rdata, 32'h12345678);
    check("ld_c3_mem_e", {31'd0, mem_e}, 32'd0);
    d_req = 1'b0;

    // 5: starvation guard, data held continuously, fetch held until served
    tick();
    if_req = 1'b1; if_addr = 9'h010;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 9'h100;
    wait_ack(1'b1, "sv_g1");
    tick();
    wait_ack(1'b1, "sv_g2");
    tick();
    wait_ack(1'b1, "sv_g3");
    tick();
    wait_ack(1'b1, "sv_g4");
    check("sv_streak4", {29'd0, dut.streak}, 32'd4);
    tick();
    wait_ack(1'b0, "sv_g5");
    check("sv_streak0", {29'd0, dut.streak}, 32'd0);
    check("sv_g5_ird", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    tick();
    wait_ack(1'b1, "sv_g6");
    d_req = 1'b0;

    // 6: reset in second ACCESS cycle aborts the load
    tick();
    d_req = 1'b1; d_rw = 1'b0; d_addr = 9'h004;
    tick();
    tick();
    check("ab_c2_mem_e", {31'd0, mem_e}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("ab_c3_idle",  {30'd0, busy, mem_e}, 32'd0);
    check("ab_c3_dack",  {31'd0, d_ack}, 32'd0);
    check("ab_c3_drd",   d_rdata, 32'd0);
    tick();
    check("ab_c4_noack", {31'd0, d_ack}, 32'd0);
    tick();
    check("ab_c5_noack", {31'd0, d_ack}, 32'd0);
    tick();
    check("ab_c6_ack",   {31'd0, d_ack}, 32'd1);
    check("ab_c6_drd",   d_rdata, 32'h01234567);
    d_req = 1'b0;
    tick();
    check("end_idle", {30'd0, busy, stall_M}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
